mm_accel_seq: RTL and testbench

Parametrised, sequential successor to the combinational matrix-multiply accelerator.
- Memory-mapped slave holding A, B and C banks plus one control/status register (CSR).
- A single MAC unit computes C = A×B (N×N) one product per cycle under an FSM, instead of an N³ combinational array.
- Adds a start/busy/done handshake, a signed mode, a sticky error flag and an interrupt. Sits on the CPU data bus beside RAM.

---
 rtl/mm_accel_pkg.sv | 34 +++
 rtl/mm_mac.sv | 42 ++++
 rtl/mm_accel_seq.sv | 192 +++++++++++++++++++
 tb/tb_mm_accel_seq.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_accel_pkg.sv
// Shared definitions for the sequential matrix-multiply accelerator:
// region layout helpers, CSR bit positions and engine states.
package mm_accel_pkg;

  localparam int CSR_BUSY = 0;
  localparam int CSR_SGN  = 1;
  localparam int CSR_DONE = 2;
  localparam int CSR_IE   = 3;
  localparam int CSR_ERR  = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLR,
    S_MAC,
    S_STORE
  } state_t;

  function automatic int a_base(input int base);
    return base;
  endfunction

  function automatic int b_base(input int n, input int base);
    return base + n * n;
  endfunction

  function automatic int c_base(input int n, input int base);
    return base + 2 * n * n;
  endfunction

  function automatic int csr_addr(input int n, input int base);
    return base + 3 * n * n;
  endfunction

endpackage

// File: rtl/mm_mac.sv
// Single multiply-accumulate lane: BITS x BITS product (signed or unsigned)
// summed into an ACC_W accumulator with synchronous clear and enable.
module mm_mac #(
  parameter int BITS  = 8,
  parameter int ACC_W = 19
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_sgn,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [BITS-1:0]  i_a,
  input  logic [BITS-1:0]  i_b,
  output logic [ACC_W-1:0] o_acc
);

  logic signed [2*BITS-1:0] w_a_s;
  logic signed [2*BITS-1:0] w_b_s;
  logic signed [2*BITS-1:0] w_prod_s;
  logic [2*BITS-1:0]        w_prod_u;
  logic [ACC_W-1:0]         w_prod_ext;
  logic [ACC_W-1:0]         r_acc;

  assign w_a_s      = {{BITS{i_a[BITS-1]}}, i_a};
  assign w_b_s      = {{BITS{i_b[BITS-1]}}, i_b};
  assign w_prod_s   = w_a_s * w_b_s;
  assign w_prod_u   = {{BITS{1'b0}}, i_a} * {{BITS{1'b0}}, i_b};
  assign w_prod_ext = i_sgn ? ACC_W'(w_prod_s) : ACC_W'(w_prod_u);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + w_prod_ext;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/mm_accel_seq.sv
// Memory-mapped N x N matrix multiplier: A/B/C banks plus CSR, computing
// C = A x B with one MAC lane, one product per cycle.
//
// state   | meaning
// S_IDLE  | waiting for start, banks freely accessible
// S_CLR   | clear accumulator for element C[i][j]
// S_MAC   | accumulate A[i][k]*B[k][j], k = 0..N-1
// S_STORE | write C[i][j], advance j then i, finish after the last element
module mm_accel_seq
  import mm_accel_pkg::*;
#(
  parameter int N      = 8,
  parameter int BITS   = 8,
  parameter int ADDR_W = 10,
  parameter int BASE   = 128,
  parameter int ACC_W  = 2 * BITS + $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic              done,
  output logic              irq
);

  localparam int NN    = N * N;
  localparam int IDX_W = $clog2(NN);
  localparam int CNT_W = $clog2(N);
  localparam logic [31:0] A_LO  = 32'(a_base(BASE));
  localparam logic [31:0] B_LO  = 32'(b_base(N, BASE));
  localparam logic [31:0] C_LO  = 32'(c_base(N, BASE));
  localparam logic [31:0] CSR_A = 32'(csr_addr(N, BASE));
  localparam logic [CNT_W-1:0] K_LAST = CNT_W'(N - 1);

  if (N < 2 || ACC_W > 32 || BASE + 3 * NN + 1 > (1 << ADDR_W)) begin : g_param_err
    $error("mm_accel_seq: illegal parameter combination");
  end

  logic [BITS-1:0]  r_a [NN];
  logic [BITS-1:0]  r_b [NN];
  logic [ACC_W-1:0] r_c [NN];

  state_t           r_state;
  logic [CNT_W-1:0] r_i, r_j, r_k;
  logic             r_busy, r_done, r_sgn, r_ie, r_err;
  logic [31:0]      r_rdata;

  logic [31:0]      w_addr;
  logic             w_in_a, w_in_b, w_in_c, w_in_csr;
  logic [IDX_W-1:0] w_a_idx, w_b_idx, w_c_idx;
  logic             w_rd, w_wr, w_ab_wr, w_ab_drop, w_csr_wr, w_start;
  logic [IDX_W-1:0] w_mac_a_idx, w_mac_b_idx, w_store_idx;
  logic [ACC_W-1:0] w_acc;
  logic [31:0]      w_csr_val, w_rd_val;
  logic             w_unused_wdata;

  assign w_addr   = 32'(addr);
  assign w_in_a   = (w_addr >= A_LO) && (w_addr < B_LO);
  assign w_in_b   = (w_addr >= B_LO) && (w_addr < C_LO);
  assign w_in_c   = (w_addr >= C_LO) && (w_addr < CSR_A);
  assign w_in_csr = (w_addr == CSR_A);
  assign w_a_idx  = IDX_W'(w_addr - A_LO);
  assign w_b_idx  = IDX_W'(w_addr - B_LO);
  assign w_c_idx  = IDX_W'(w_addr - C_LO);

  assign w_rd      = sel & ~wr_en;
  assign w_wr      = sel & wr_en;
  assign w_ab_wr   = w_wr & (w_in_a | w_in_b);
  assign w_ab_drop = w_ab_wr & r_busy;
  assign w_csr_wr  = w_wr & w_in_csr;
  assign w_start   = w_csr_wr & wdata[CSR_BUSY] & ~r_busy;

  assign w_mac_a_idx = IDX_W'(int'(r_i) * N + int'(r_k));
  assign w_mac_b_idx = IDX_W'(int'(r_k) * N + int'(r_j));
  assign w_store_idx = IDX_W'(int'(r_i) * N + int'(r_j));

  assign w_csr_val = 32'({r_err, r_ie, r_done, r_sgn, r_busy});
  assign w_unused_wdata = ^wdata[31:BITS];

  mm_mac #(
    .BITS  (BITS),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .i_sgn (r_sgn),
    .i_clr (r_state == S_CLR),
    .i_en  (r_state == S_MAC),
    .i_a   (r_a[w_mac_a_idx]),
    .i_b   (r_b[w_mac_b_idx]),
    .o_acc (w_acc)
  );

  // Operand banks stay frozen while the engine runs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NN; n++) begin
        r_a[n] <= '0;
        r_b[n] <= '0;
      end
    end else if (w_ab_wr && !r_busy) begin
      if (w_in_a) r_a[w_a_idx] <= wdata[BITS-1:0];
      else        r_b[w_b_idx] <= wdata[BITS-1:0];
    end
  end

  always_comb begin
    w_rd_val = '0;
    if (w_in_a)        w_rd_val = r_sgn ? 32'($signed(r_a[w_a_idx])) : 32'(r_a[w_a_idx]);
    else if (w_in_b)   w_rd_val = r_sgn ? 32'($signed(r_b[w_b_idx])) : 32'(r_b[w_b_idx]);
    else if (w_in_c)   w_rd_val = r_sgn ? 32'($signed(r_c[w_c_idx])) : 32'(r_c[w_c_idx]);
    else if (w_in_csr) w_rd_val = w_csr_val;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_rdata <= '0;
    else if (w_rd) r_rdata <= w_rd_val;
    else           r_rdata <= '0;
  end

  // CSR writes come first so a completing run's done/err set wins over W1C.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_i     <= '0;
      r_j     <= '0;
      r_k     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sgn   <= 1'b0;
      r_ie    <= 1'b0;
      r_err   <= 1'b0;
      for (int n = 0; n < NN; n++) r_c[n] <= '0;
    end else begin
      if (w_csr_wr) begin
        r_ie <= wdata[CSR_IE];
        if (!r_busy)         r_sgn  <= wdata[CSR_SGN];
        if (wdata[CSR_DONE]) r_done <= 1'b0;
        if (wdata[CSR_ERR])  r_err  <= 1'b0;
      end
      if (w_ab_drop) r_err <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_CLR;
            r_busy  <= 1'b1;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
          end
        end
        S_CLR: begin
          r_k     <= '0;
          r_state <= S_MAC;
        end
        S_MAC: begin
          if (r_k == K_LAST) r_state <= S_STORE;
          else               r_k     <= r_k + CNT_W'(1);
        end
        S_STORE: begin
          r_c[w_store_idx] <= w_acc;
          if (r_j == K_LAST) begin
            r_j <= '0;
            if (r_i == K_LAST) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_i     <= r_i + CNT_W'(1);
              r_state <= S_CLR;
            end
          end else begin
            r_j     <= r_j + CNT_W'(1);
            r_state <= S_CLR;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rdata = r_rdata;
  assign busy  = r_busy;
  assign done  = r_done;
  assign irq   = r_done & r_ie;

endmodule

// File: tb/tb_mm_accel_seq.sv
// Self-checking bench for mm_accel_seq: an N=2 and an N=8 instance on a
// shared bus, with read expectations queued from a reference model.
module tb_mm_accel_seq;

  localparam int BASE = 128;
  localparam int A2 = 128, B2 = 132, C2 = 136, CSR2 = 140;
  localparam int A8 = 128, B8 = 192, C8 = 256, CSR8 = 320;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel2 = 1'b0, sel8 = 1'b0, wr_en = 1'b0;
  logic [9:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata2, rdata8;
  logic        busy2, done2, irq2, busy8, done8, irq8;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  int          ma[64];
  int          mb[64];

  always #5 clk = ~clk;

  mm_accel_seq #(.N(2)) u_dut2 (
    .clk(clk), .rst(rst), .sel(sel2), .wr_en(wr_en), .addr(addr), .wdata(wdata),
    .rdata(rdata2), .busy(busy2), .done(done2), .irq(irq2)
  );

  mm_accel_seq #(.N(8)) u_dut8 (
    .clk(clk), .rst(rst), .sel(sel8), .wr_en(wr_en), .addr(addr), .wdata(wdata),
    .rdata(rdata8), .busy(busy8), .done(done8), .irq(irq8)
  );

  function automatic int ext8(input int v, input bit sgn);
    logic [7:0] b;
    b = v[7:0];
    return sgn ? int'($signed(b)) : int'(b);
  endfunction

  function automatic logic [31:0] model_c(input int n, input int i, input int j, input bit sgn);
    int sum;
    sum = 0;
    for (int k = 0; k < n; k++) sum += ext8(ma[i*n+k], sgn) * ext8(mb[k*n+j], sgn);
    return 32'(sum);
  endfunction

  task automatic bus_wr(input bit big, input int a, input logic [31:0] d);
    @(negedge clk);
    sel2 = !big; sel8 = big; wr_en = 1'b1; addr = 10'(a); wdata = d;
    @(posedge clk); #1;
    sel2 = 1'b0; sel8 = 1'b0; wr_en = 1'b0;
  endtask

  task automatic bus_rd(input bit big, input int a, output logic [31:0] d);
    @(negedge clk);
    sel2 = !big; sel8 = big; wr_en = 1'b0; addr = 10'(a);
    @(posedge clk); #1;
    d = big ? rdata8 : rdata2;
    sel2 = 1'b0; sel8 = 1'b0;
  endtask

  task automatic load_ab(input bit big, input int n);
    for (int x = 0; x < n*n; x++) begin
      bus_wr(big, BASE + x, 32'(ma[x]));
      bus_wr(big, BASE + n*n + x, 32'(mb[x]));
    end
  endtask

  task automatic wait_done(input bit big, input int limit, output int cyc);
    int c;
    c = 0;
    cyc = -1;
    while (cyc < 0 && c < limit) begin
      @(posedge clk); #1;
      c++;
      if ((big ? done8 : done2) === 1'b1) cyc = c;
    end
  endtask

  task automatic set_small_ab();
    for (int x = 0; x < 4; x++) begin
      ma[x] = x + 1;
      mb[x] = x + 5;
    end
  endtask

  task automatic test_reset();
    logic [31:0] got, exp;
    #1;
    n_cmp++;
    if ({busy2, done2, irq2, busy8, done8, irq8} !== 6'b0) begin
      n_bad++; $display("FAIL reset_flags: got %b required 000000", {busy2, done2, irq2, busy8, done8, irq8});
    end
    n_cmp++;
    if (rdata2 !== 32'h0 || rdata8 !== 32'h0) begin
      n_bad++; $display("FAIL reset_rdata: got %h/%h required 0", rdata2, rdata8);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    bus_rd(0, CSR2, got);
    exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL reset_csr2: got %h required %h", got, exp); end
    bus_rd(1, CSR8, got);
    exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL reset_csr8: got %h required %h", got, exp); end
  endtask

  task automatic test_unsigned_n2();
    logic [31:0] got, exp;
    int cyc;
    set_small_ab();
    load_ab(0, 2);
    bus_wr(0, CSR2, 32'h1);
    n_cmp++;
    if (busy2 !== 1'b1) begin n_bad++; $display("FAIL u2_busy_after_start: got %b required 1", busy2); end
    wait_done(0, 100, cyc);
    n_cmp++;
    if (cyc != 16) begin n_bad++; $display("FAIL u2_done_cycle: got %0d required 16", cyc); end
    n_cmp++;
    if (irq2 !== 1'b0 || busy2 !== 1'b0) begin
      n_bad++; $display("FAIL u2_irq_busy: got irq=%b busy=%b required 0/0", irq2, busy2);
    end
    for (int e = 0; e < 4; e++) exp_q.push_back(model_c(2, e / 2, e % 2, 1'b0));
    for (int e = 0; e < 4; e++) begin
      bus_rd(0, C2 + e, got);
      exp = exp_q.pop_front(); n_cmp++;
      if (got !== exp) begin n_bad++; $display("FAIL u2_c[%0d]: got %h required %h", e, got, exp); end
    end
    exp_q.push_back(32'h4);
    bus_rd(0, CSR2, got);
    exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL u2_csr: got %h required %h", got, exp); end
  endtask

  task automatic test_identity_n8();
    logic [31:0] got, exp;
    int cyc, bad;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        ma[i*8+j] = (i == j) ? 1 : 0;
        mb[i*8+j] = i * 8 + j;
      end
    load_ab(1, 8);
    bus_wr(1, CSR8, 32'h9);
    wait_done(1, 1000, cyc);
    n_cmp++;
    if (cyc != 640) begin n_bad++; $display("FAIL n8_done_cycle: got %0d required 640", cyc); end
    n_cmp++;
    if (irq8 !== 1'b1) begin n_bad++; $display("FAIL n8_irq: got %b required 1", irq8); end
    for (int e = 0; e < 64; e++) exp_q.push_back(model_c(8, e / 8, e % 8, 1'b0));
    bad = 0;
    for (int e = 0; e < 64; e++) begin
      bus_rd(1, C8 + e, got);
      exp = exp_q.pop_front(); n_cmp++;
      if (got !== exp) begin
        n_bad++; bad++;
        if (bad <= 8) $display("FAIL n8_c[%0d]: got %h required %h", e, got, exp);
      end
    end
    bus_wr(1, CSR8, 32'h4);
    n_cmp++;
    if (done8 !== 1'b0 || irq8 !== 1'b0) begin
      n_bad++; $display("FAIL n8_w1c_done: got done=%b irq=%b required 0/0", done8, irq8);
    end
  endtask

  task automatic test_signed_n2();
    logic [31:0] got, exp;
    int cyc;
    for (int x = 0; x < 4; x++) begin ma[x] = 8'hFF; mb[x] = 2; end
    load_ab(0, 2);
    bus_wr(0, CSR2, 32'h7);
    n_cmp++;
    if (done2 !== 1'b0 || busy2 !== 1'b1) begin
      n_bad++; $display("FAIL s2_clear_and_start: got done=%b busy=%b required 0/1", done2, busy2);
    end
    wait_done(0, 100, cyc);
    n_cmp++;
    if (cyc != 16) begin n_bad++; $display("FAIL s2_done_cycle: got %0d required 16", cyc); end
    for (int e = 0; e < 4; e++) exp_q.push_back(model_c(2, e / 2, e % 2, 1'b1));
    for (int e = 0; e < 4; e++) begin
      bus_rd(0, C2 + e, got);
      exp = exp_q.pop_front(); n_cmp++;
      if (got !== exp) begin n_bad++; $display("FAIL s2_c[%0d]: got %h required %h", e, got, exp); end
    end
    exp_q.push_back(32'hFFFF_FFFF);
    exp_q.push_back(32'h6);
    bus_rd(0, A2, got);
    exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL s2_a00_sext: got %h required %h", got, exp); end
    bus_rd(0, CSR2, got);
    exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL s2_csr: got %h required %h", got, exp); end
  endtask

  task automatic test_busy_drop();
    logic [31:0] got, exp;
    int cyc;
    set_small_ab();
    load_ab(0, 2);
    bus_wr(0, CSR2, 32'h5);
    bus_wr(0, A2, 32'h9);
    bus_wr(0, CSR2, 32'h1);
    exp_q.push_back(32'h11);
    bus_rd(0, CSR2, got);
    exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL bd_csr_busy_err: got %h required %h", got, exp); end
    wait_done(0, 100, cyc);
    n_cmp++;
    if (cyc != 13) begin n_bad++; $display("FAIL bd_done_cycle: got %0d required 13", cyc); end
    repeat (20) @(posedge clk);
    #1;
    n_cmp++;
    if (busy2 !== 1'b0) begin n_bad++; $display("FAIL bd_single_run: got busy=%b required 0", busy2); end
    for (int e = 0; e < 4; e++) exp_q.push_back(model_c(2, e / 2, e % 2, 1'b0));
    exp_q.push_back(32'h1);
    for (int e = 0; e < 4; e++) begin
      bus_rd(0, C2 + e, got);
      exp = exp_q.pop_front(); n_cmp++;
      if (got !== exp) begin n_bad++; $display("FAIL bd_c[%0d]: got %h required %h", e, got, exp); end
    end
    bus_rd(0, A2, got);
    exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL bd_a00_kept: got %h required %h", got, exp); end
    bus_wr(0, CSR2, 32'h10);
    exp_q.push_back(32'h4);
    bus_rd(0, CSR2, got);
    exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL bd_err_w1c: got %h required %h", got, exp); end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] got, exp;
    int cyc;
    bus_wr(0, CSR2, 32'h1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    sel2 = 1'b1; wr_en = 1'b0; addr = 10'(CSR2);
    @(posedge clk); #1;
    n_cmp++;
    if (rdata2 !== 32'h5) begin n_bad++; $display("FAIL rm_pre_csr: got %h required 00000005", rdata2); end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy2, done2, irq2} !== 3'b0 || rdata2 !== 32'h0) begin
      n_bad++; $display("FAIL rm_async_clear: got busy=%b done=%b irq=%b rdata=%h required 0", busy2, done2, irq2, rdata2);
    end
    sel2 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int a = A2; a <= CSR2; a++) exp_q.push_back(32'h0);
    for (int a = A2; a <= CSR2; a++) begin
      bus_rd(0, a, got);
      exp = exp_q.pop_front(); n_cmp++;
      if (got !== exp) begin n_bad++; $display("FAIL rm_bank_zero[%0d]: got %h required %h", a, got, exp); end
    end
    set_small_ab();
    load_ab(0, 2);
    bus_wr(0, CSR2, 32'h1);
    wait_done(0, 100, cyc);
    n_cmp++;
    if (cyc != 16) begin n_bad++; $display("FAIL rm_rerun_cycle: got %0d required 16", cyc); end
    for (int e = 0; e < 4; e++) exp_q.push_back(model_c(2, e / 2, e % 2, 1'b0));
    for (int e = 0; e < 4; e++) begin
      bus_rd(0, C2 + e, got);
      exp = exp_q.pop_front(); n_cmp++;
      if (got !== exp) begin n_bad++; $display("FAIL rm_c[%0d]: got %h required %h", e, got, exp); end
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] got, exp;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    bus_rd(0, BASE - 1, got);
    exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL um_read_below: got %h required %h", got, exp); end
    bus_rd(0, CSR2 + 1, got);
    exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL um_read_above: got %h required %h", got, exp); end
    bus_wr(0, C2, 32'h1234);
    bus_wr(0, BASE - 1, 32'hAB);
    exp_q.push_back(model_c(2, 0, 0, 1'b0));
    exp_q.push_back(32'h1);
    bus_rd(0, C2, got);
    exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL um_c_write_ignored: got %h required %h", got, exp); end
    bus_rd(0, A2, got);
    exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL um_a_untouched: got %h required %h", got, exp); end
    @(posedge clk); #1;
    n_cmp++;
    if (rdata2 !== 32'h0) begin n_bad++; $display("FAIL um_rdata_idle: got %h required 0", rdata2); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_unsigned_n2();
    test_identity_n8();
    test_signed_n2();
    test_busy_drop();
    test_reset_mid_run();
    test_unmapped();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
